pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Run / stall / flush / drain controller for a five-stage in-order pipeline.
// A start request moves the block from IDLE into RUN. In RUN it arbitrates
// between a taken branch, a load-use hazard, a fetched HALT and a decoded jump.
// A HALT drains the four downstream stages and then parks the block in HALTED
// until reset. Pipeline-register controls are decoded combinationally from the
// registered state and the current inputs. Cycle and stall statistics are
// registered and saturate at their maximum value.

module pipeline_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt_fetched,
   input  logic        id_ex_mem_rd,
   input  logic [2:0]  id_ex_rd,
   input  logic [2:0]  if_id_rs,
   input  logic [2:0]  if_id_rt,
   input  logic        if_id_uses_rs,
   input  logic        if_id_uses_rt,
   input  logic        jump_id,
   input  logic        branch_taken,
   output logic        pc_wr,
   output logic        if_id_wr,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        busy,
   output logic        halted,
   output logic [15:0] cycle_cnt,
   output logic [7:0]  stall_cnt
);

   // Sequencer states, kept as plain two-bit constants
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   // The drain counter value seen in the last of the four DRAIN cycles
   // (ID, EX, MEM and WB each empty out in turn)
   localparam logic [1:0]  DRAIN_LAST = 2'd3;
   localparam logic [15:0] CYCLE_MAX  = 16'hFFFF;
   localparam logic [7:0]  STALL_MAX  = 8'hFF;

   logic [1:0]  state_q, state_d;
   logic [1:0]  drain_q, drain_d;
   logic [15:0] cycle_q, cycle_d;
   logic [7:0]  stall_q, stall_d;

   logic        rs_match;
   logic        rt_match;
   logic        hazard;
   logic        stall_evt;

   // Load-use hazard: the load in EX writes a register that ID reads.
   // Register 0 is an ordinary register here, so it can create a hazard too.
   always_comb begin
      rs_match = if_id_uses_rs && (if_id_rs == id_ex_rd);
      rt_match = if_id_uses_rt && (if_id_rt == id_ex_rd);
      hazard   = id_ex_mem_rd && (rs_match || rt_match);
   end

   // Next-state selection and pipeline-control decode, in priority order
   always_comb begin
      // NOTE: every signal written in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      drain_d      = drain_q;
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      stall_evt    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The pipeline is held empty until a run is requested
            if (start) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (branch_taken) begin
               // Redirect fetch and squash both wrong-path instructions
               pc_wr        = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (hazard) begin
               // Freeze PC and IF/ID; send one bubble into EX
               pc_wr        = 1'b0;
               if_id_wr     = 1'b0;
               if_id_flush  = 1'b0;
               id_ex_bubble = 1'b1;
               stall_evt    = 1'b1;
            end else if (halt_fetched) begin
               // Stop fetching and drop the HALT; let older work drain out
               pc_wr        = 1'b0;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b0;
               state_d      = ST_DRAIN;
               drain_d      = 2'd0;
            end else if (jump_id) begin
               // The target is known in ID; the instruction fetched behind the jump is discarded
               pc_wr        = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b0;
            end else begin
               pc_wr        = 1'b1;
               if_id_wr     = 1'b1;
               if_id_flush  = 1'b0;
               id_ex_bubble = 1'b0;
            end
         end

         ST_DRAIN: begin
            if (branch_taken) begin
               // A branch still in flight overrides the HALT: resume running
               pc_wr        = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               state_d      = ST_RUN;
               drain_d      = 2'd0;
            end else begin
               pc_wr        = 1'b0;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b0;
               if (drain_q == DRAIN_LAST) begin
                  state_d = ST_HALTED;
                  drain_d = 2'd0;
               end else begin
                  drain_d = drain_q + 2'd1;
               end
            end
         end

         ST_HALTED: begin
            // Terminal state: the controls match IDLE and start is ignored
            state_d = ST_HALTED;
         end

         default: begin
            state_d = ST_IDLE;
            drain_d = 2'd0;
         end
      endcase
   end

   // Status flags follow the registered state only
   always_comb begin
      busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      halted = (state_q == ST_HALTED);
   end

   // Saturating next values for the run-cycle and load-use stall counters
   always_comb begin
      cycle_d = cycle_q;
      stall_d = stall_q;
      if (busy && (cycle_q != CYCLE_MAX)) begin
         cycle_d = cycle_q + 16'd1;
      end
      if (stall_evt && (stall_q != STALL_MAX)) begin
         stall_d = stall_q + 8'd1;
      end
   end

   // State, drain counter and statistics registers; reset takes effect at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         drain_q <= 2'd0;
         cycle_q <= 16'd0;
         stall_q <= 8'd0;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values, whatever order the statements appear in.
         state_q <= state_d;
         drain_q <= drain_d;
         cycle_q <= cycle_d;
         stall_q <= stall_d;
      end
   end

   // Counter outputs come straight from their registers
   always_comb begin
      cycle_cnt = cycle_q;
      stall_cnt = stall_q;
   end

`ifndef SYNTHESIS
   // IF/ID is never written and flushed in the same cycle
   a_flush_wr_excl : assert property (@(posedge clk) disable iff (rst)
      !(if_id_flush && if_id_wr));

   // A stall always freezes the PC
   a_stall_freezes_pc : assert property (@(posedge clk) disable iff (rst)
      stall_evt |-> !pc_wr);
`endif

endmodule
